// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router allocator.
//  - flit type encodings carried on in_flit_id
//  - port index constants (N, E, W, S, L)
//  - per-output allocation state
package noc_pkg;

   localparam logic [2:0] HEADER  = 3'b001;
   localparam logic [2:0] PAYLOAD = 3'b010;
   localparam logic [2:0] TAIL    = 3'b100;

   localparam int unsigned PORT_N = 0;
   localparam int unsigned PORT_E = 1;
   localparam int unsigned PORT_W = 2;
   localparam int unsigned PORT_S = 3;
   localparam int unsigned PORT_L = 4;

   typedef enum logic [0:0] {
      IDLE,
      BUSY
   } alloc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//  clk, rst : clock, synchronous active-high reset (pointer -> 0)
//  req      : request vector
//  update   : accept the current winner; pointer moves to winner+1 (mod N)
//  gnt      : one-hot winner, searched upward from the pointer
//  gnt_idx  : binary index of the winner (0 when no request)
module rr_arbiter #(
   parameter int unsigned N = 5,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            update,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] gnt_idx
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW:0]   pos;

   // Walk from the farthest position back towards the pointer so the last hit,
   // i.e. the one closest to the pointer, wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      pos     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, ptr_q} + (IdxW + 1)'(k);
         if (pos >= (IdxW + 1)'(N)) begin
            pos = pos - (IdxW + 1)'(N);
         end
         if (req[pos[IdxW-1:0]]) begin
            gnt                 = '0;
            gnt[pos[IdxW-1:0]]  = 1'b1;
            gnt_idx             = pos[IdxW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (update) begin
         ptr_d = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + IdxW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/noc_output_allocator.sv
// Switch allocator for the 5-port mesh router. Each output arbitrates round-robin
// among inputs presenting a HEADER for it, then holds the grant for the whole packet
// (wormhole) and moves one flit per cycle while downstream credits are available.
//  clk, rst   : clock, synchronous active-high reset
//  in_valid   : input FIFO i non-empty
//  in_flit_id : flit type at head of input i, [3i+2:3i]
//  in_req     : bit [i*NPORTS+o] = input i wants output o
//  credit_in  : one credit returned on output o
//  in_rd_en   : pop head flit of input i
//  xbar_sel   : input index connected to output o, [3o+2:3o]
//  out_valid  : flit on output o valid this cycle
//  credit_err : sticky credit counter overflow
module noc_output_allocator
   import noc_pkg::*;
#(
   parameter int unsigned NPORTS    = 5,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        in_valid,
   input  logic [3*NPORTS-1:0]      in_flit_id,
   input  logic [NPORTS*NPORTS-1:0] in_req,
   input  logic [NPORTS-1:0]        credit_in,
   output logic [NPORTS-1:0]        in_rd_en,
   output logic [3*NPORTS-1:0]      xbar_sel,
   output logic [NPORTS-1:0]        out_valid,
   output logic                     credit_err
);

   localparam int unsigned IdxW = $clog2(NPORTS);
   localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
   localparam logic [CntW-1:0] CreditMax = CntW'(BUF_DEPTH);

   logic [NPORTS-1:0] busy;
   logic [NPORTS-1:0] xfer;
   logic [NPORTS-1:0] owned;
   logic [NPORTS-1:0] ovf;
   logic [IdxW-1:0]   owner [NPORTS];
   logic [2:0]        flit_id [NPORTS];
   logic              credit_err_q;

   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         flit_id[i] = in_flit_id[3*i +: 3];
      end
   end

   // An input locked to a busy output must not be picked up by another output.
   always_comb begin
      owned = '0;
      for (int o = 0; o < NPORTS; o++) begin
         if (busy[o]) begin
            owned[owner[o]] = 1'b1;
         end
      end
   end

   always_comb begin
      in_rd_en = '0;
      for (int o = 0; o < NPORTS; o++) begin
         if (xfer[o]) begin
            in_rd_en[owner[o]] = 1'b1;
         end
      end
   end

   assign out_valid = xfer;

   for (genvar o = 0; o < NPORTS; o++) begin : g_out
      alloc_state_t    state_q, state_d;
      logic [IdxW-1:0] owner_q, owner_d;
      logic [CntW-1:0] credit_q, credit_d;
      logic [NPORTS-1:0] cand;
      logic [NPORTS-1:0] arb_gnt;
      logic [IdxW-1:0]   arb_idx;
      logic              has_credit;
      logic              grant;

      always_comb begin
         for (int i = 0; i < NPORTS; i++) begin
            cand[i] = in_valid[i] & in_req[i*NPORTS + o] & (flit_id[i] == HEADER) & ~owned[i];
         end
      end

      rr_arbiter #(
         .N (NPORTS)
      ) u_arb (
         .clk     (clk),
         .rst     (rst),
         .req     (cand),
         .update  (grant),
         .gnt     (arb_gnt),
         .gnt_idx (arb_idx)
      );

      assign has_credit = (credit_q != '0);
      assign grant      = (state_q == IDLE) & (|arb_gnt) & has_credit;
      // Reset drops an in-flight grant in the same cycle it is raised.
      assign xfer[o]    = ~rst & (state_q == BUSY) & in_valid[owner_q] & has_credit;
      assign busy[o]    = (state_q == BUSY);
      assign owner[o]   = owner_q;
      assign xbar_sel[3*o +: 3] = 3'(owner_q);

      always_comb begin
         state_d = state_q;
         owner_d = owner_q;
         unique case (state_q)
            IDLE: begin
               if (grant) begin
                  state_d = BUSY;
                  owner_d = arb_idx;
               end
            end
            BUSY: begin
               if (xfer[o] && (flit_id[owner_q] == TAIL)) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Return and consume in the same cycle cancel; a return at full saturates.
      assign ovf[o] = credit_in[o] & ~xfer[o] & (credit_q == CreditMax);

      always_comb begin
         credit_d = credit_q;
         if (credit_in[o] && !xfer[o]) begin
            if (credit_q != CreditMax) begin
               credit_d = credit_q + CntW'(1);
            end
         end else if (!credit_in[o] && xfer[o]) begin
            credit_d = credit_q - CntW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            credit_q <= CreditMax;
         end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_err_q <= 1'b0;
      end else if (|ovf) begin
         credit_err_q <= 1'b1;
      end
   end

   assign credit_err = credit_err_q;

   // Each input may target at most one output at a time.
   for (genvar i = 0; i < NPORTS; i++) begin : g_req_chk
      always_ff @(posedge clk) begin
         if (!rst && in_valid[i]) begin
            assert ($onehot0(in_req[i*NPORTS +: NPORTS]));
         end
      end
   end

endmodule

// File: tb/tb_noc_output_allocator.sv
// Scoreboard bench for noc_output_allocator: per-input flit queues feed the DUT,
// a behavioural model predicts each cycle's outputs into exp_q, and a negedge
// monitor pops and compares.
module tb_noc_output_allocator;

   localparam int N  = 5;
   localparam int BD = 4;
   localparam logic [2:0] HDR = 3'b001;
   localparam logic [2:0] PLD = 3'b010;
   localparam logic [2:0] TL  = 3'b100;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     in_valid;
   logic [3*N-1:0]   in_flit_id;
   logic [N*N-1:0]   in_req;
   logic [N-1:0]     credit_in;
   logic [N-1:0]     in_rd_en;
   logic [3*N-1:0]   xbar_sel;
   logic [N-1:0]     out_valid;
   logic             credit_err;

   noc_output_allocator #(
      .NPORTS    (N),
      .BUF_DEPTH (BD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_flit_id (in_flit_id),
      .in_req     (in_req),
      .credit_in  (credit_in),
      .in_rd_en   (in_rd_en),
      .xbar_sel   (xbar_sel),
      .out_valid  (out_valid),
      .credit_err (credit_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]   ov;
      logic [N-1:0]   rd;
      logic [3*N-1:0] sel;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   dut_cnt[N];

   // Source FIFOs: each entry is (dst << 4) | flit type.
   int   src_q[N][$];
   int   gap_pct = 0;

   // Reference model state (owner -1 = idle).
   int   m_own[N];
   int   m_ptr[N];
   int   m_cred[N];
   int   pend[N];
   bit   m_err;

   logic [N-1:0] cur_v;
   logic [2:0]   cur_ft[N];
   int           cur_dst[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      for (int o = 0; o < N; o++) begin
         m_own[o]  = -1;
         m_ptr[o]  = 0;
         m_cred[o] = BD;
         pend[o]   = 0;
      end
      m_err = 1'b0;
   endfunction

   task automatic model_step(input logic r, input logic [N-1:0] c, output exp_t e);
      int nxt_own[N];
      bit owned[N];
      int g;
      int i;
      e     = '0;
      e.err = m_err;
      if (r) begin
         model_reset();
         return;
      end
      for (int k = 0; k < N; k++) owned[k] = 1'b0;
      for (int o = 0; o < N; o++) if (m_own[o] >= 0) owned[m_own[o]] = 1'b1;
      for (int o = 0; o < N; o++) begin
         if (m_own[o] >= 0) begin
            g = m_own[o];
            e.sel[3*o +: 3] = 3'(g);
            if (cur_v[g] && m_cred[o] > 0) begin
               e.ov[o] = 1'b1;
               e.rd[g] = 1'b1;
            end
         end
      end
      for (int o = 0; o < N; o++) begin
         nxt_own[o] = m_own[o];
         if (m_own[o] >= 0) begin
            if (e.ov[o] && cur_ft[m_own[o]] == TL) nxt_own[o] = -1;
         end else if (m_cred[o] > 0) begin
            for (int k = 0; k < N; k++) begin
               i = (m_ptr[o] + k) % N;
               if (cur_v[i] && cur_dst[i] == o && cur_ft[i] == HDR && !owned[i]) begin
                  nxt_own[o] = i;
                  m_ptr[o]   = (i + 1) % N;
                  break;
               end
            end
         end
      end
      for (int o = 0; o < N; o++) begin
         if (c[o] && !e.ov[o]) begin
            if (m_cred[o] == BD) m_err = 1'b1;
            else m_cred[o]++;
         end else if (!c[o] && e.ov[o]) begin
            m_cred[o]--;
         end
         pend[o] = pend[o] + int'(e.ov[o]) - int'(c[o]);
         if (pend[o] < 0) pend[o] = 0;
         m_own[o] = nxt_own[o];
      end
   endtask

   task automatic push_pkt(input int s, input int d, input int len);
      src_q[s].push_back((d << 4) | int'(HDR));
      for (int k = 0; k < len - 2; k++) src_q[s].push_back((d << 4) | int'(PLD));
      src_q[s].push_back((d << 4) | int'(TL));
   endtask

   function automatic logic [N-1:0] auto_credit(input int pct);
      logic [N-1:0] c;
      for (int o = 0; o < N; o++) c[o] = (pend[o] > 0) && ($urandom_range(99) < pct);
      return c;
   endfunction

   // Starts and ends at posedge+1.
   task automatic run_cycle(input logic [N-1:0] c);
      exp_t e;
      int   f;
      in_req     = '0;
      in_flit_id = '0;
      for (int i = 0; i < N; i++) begin
         cur_v[i]   = 1'b0;
         cur_ft[i]  = 3'b000;
         cur_dst[i] = 0;
         if (src_q[i].size() > 0) begin
            f          = src_q[i][0];
            cur_ft[i]  = 3'(f & 7);
            cur_dst[i] = (f >> 4) & 15;
            cur_v[i]   = ($urandom_range(99) >= gap_pct);
         end
         if (cur_v[i]) begin
            in_flit_id[3*i +: 3]     = cur_ft[i];
            in_req[i*N + cur_dst[i]] = 1'b1;
         end
      end
      in_valid  = cur_v;
      credit_in = c;
      model_step(rst, c, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rst) src_q[i].delete();
         else if (e.rd[i]) void'(src_q[i].pop_front());
      end
   endtask

   function automatic bit work_left(input int pct);
      bit w = 1'b0;
      for (int o = 0; o < N; o++) begin
         if (src_q[o].size() > 0 || m_own[o] >= 0) w = 1'b1;
         if (pct > 0 && pend[o] > 0) w = 1'b1;
      end
      return w;
   endfunction

   task automatic drain(input string name, input int pct, input int max_cycles);
      int n = 0;
      while (work_left(pct) && n < max_cycles) begin
         run_cycle(auto_credit(pct));
         n++;
      end
      checks++;
      if (n >= max_cycles) begin
         errors++;
         $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, max_cycles);
      end
   endtask

   // Monitor: one expected record per driven cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int o = 0; o < N; o++) if (out_valid[o]) dut_cnt[o]++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.ov));
            chk("in_rd_en", 32'(in_rd_en), 32'(e.rd));
            chk("credit_err", 32'(credit_err), 32'(e.err));
            for (int o = 0; o < N; o++) begin
               if (e.ov[o]) chk($sformatf("xbar_sel[%0d]", o), 32'(xbar_sel[3*o +: 3]),
                                32'(e.sel[3*o +: 3]));
            end
         end
      end
   end

   initial begin
      int b0;
      int b1;
      rst        = 1'b1;
      in_valid   = '0;
      in_flit_id = '0;
      in_req     = '0;
      credit_in  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_in_rd_en", 32'(in_rd_en), 32'h0);
      chk("reset_xbar_sel", 32'(xbar_sel), 32'h0);
      chk("reset_credit_err", 32'(credit_err), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // W -> E, 3 flits, no credit return: 3 flits out, 1 credit left.
      push_pkt(2, 1, 3);
      b0 = dut_cnt[1];
      repeat (6) run_cycle('0);
      chk("t1_flits_E", 32'(dut_cnt[1] - b0), 32'd3);
      push_pkt(2, 1, 2);
      b0 = dut_cnt[1];
      repeat (5) run_cycle('0);
      chk("t1_last_credit_E", 32'(dut_cnt[1] - b0), 32'd1);
      drain("t1", 100, 200);

      // N, S, L contend for L; then repeated N+S rounds to rotate the pointer.
      push_pkt(0, 4, 2);
      push_pkt(3, 4, 2);
      push_pkt(4, 4, 2);
      drain("t2a", 100, 200);
      repeat (2) begin
         push_pkt(0, 4, 3);
         push_pkt(3, 4, 3);
         drain("t2b", 100, 200);
      end

      // Credit exhaustion on N with a 6-flit packet from E.
      push_pkt(1, 0, 6);
      b0 = dut_cnt[0];
      repeat (8) run_cycle('0);
      chk("t3_flits_before_stall", 32'(dut_cnt[0] - b0), 32'd4);
      b0 = dut_cnt[0];
      run_cycle(5'b00001);
      repeat (3) run_cycle('0);
      chk("t3_one_per_credit", 32'(dut_cnt[0] - b0), 32'd1);
      drain("t3", 100, 200);

      // Return coincident with transfer on S keeps it full; a return at full flags error.
      push_pkt(2, 3, 3);
      run_cycle('0);
      repeat (3) run_cycle(5'b01000);
      chk("t4_no_err_yet", 32'(credit_err), 32'h0);
      run_cycle(5'b01000);
      chk("t4_overflow_err", 32'(credit_err), 32'h1);
      repeat (3) run_cycle('0);
      chk("t4_err_sticky", 32'(credit_err), 32'h1);

      // Disjoint concurrent flows E->W and N->S.
      push_pkt(1, 2, 5);
      push_pkt(0, 3, 5);
      b0 = dut_cnt[2];
      b1 = dut_cnt[3];
      repeat (6) run_cycle(auto_credit(100));
      chk("t5_flits_W", 32'(dut_cnt[2] - b0), 32'd5);
      chk("t5_flits_S", 32'(dut_cnt[3] - b1), 32'd5);
      drain("t5", 100, 200);

      // Random traffic with input bubbles and random credit return.
      gap_pct = 20;
      for (int i = 0; i < N; i++) begin
         for (int p = 0; p < 6; p++) push_pkt(i, int'($urandom_range(N - 1)), int'($urandom_range(5, 2)));
      end
      drain("random", 60, 5000);
      gap_pct = 0;

      // Reset mid-packet, then a fresh packet.
      push_pkt(4, 0, 4);
      repeat (3) run_cycle(auto_credit(100));
      rst = 1'b1;
      run_cycle('0);
      rst = 1'b0;
      chk("t6_err_cleared", 32'(credit_err), 32'h0);
      run_cycle('0);
      push_pkt(4, 0, 3);
      b0 = dut_cnt[0];
      drain("t6", 100, 200);
      chk("t6_fresh_flits", 32'(dut_cnt[0] - b0), 32'd3);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
